// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the memory it fills.
package imem_loader_pkg;

    localparam int unsigned IMEM_BYTES = 256;
    localparam int unsigned CHK_W      = 8;
    localparam int unsigned LEN_W      = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    // Modulo-2^CHK_W running sum used for the trailing frame checksum.
    function automatic logic [CHK_W-1:0] chk8_add(input logic [CHK_W-1:0] acc,
                                                  input logic [7:0]       b);
        return acc + CHK_W'(b);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Loads a framed byte stream (len, payload, checksum) into instruction memory
// and keeps the core in reset until a complete, checksum-verified image exists.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_BYTES = IMEM_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   bytes_written
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    loader_state_t    state;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] count_q;
    logic [CHK_W-1:0] chk_q;
    logic [LEN_W-1:0] hdr_len;
    logic             accept;

    // Ready depends on state alone so the host can never see a valid->ready loop.
    assign rx_ready = (state == HDR_LO) || (state == HDR_HI) ||
                      (state == DATA)   || (state == CHK);
    assign accept   = rx_valid && rx_ready;
    assign hdr_len  = {rx_data, len_q[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            len_q         <= '0;
            count_q       <= '0;
            chk_q         <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_hold      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            bytes_written <= '0;
        end else begin
            mem_we <= 1'b0;
            if (mem_we) begin
                bytes_written <= bytes_written + CNT_W'(1);
            end
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state         <= HDR_LO;
                        len_q         <= '0;
                        count_q       <= '0;
                        chk_q         <= '0;
                        cpu_hold      <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        bytes_written <= '0;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        len_q[7:0] <= rx_data;
                        state      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        len_q[15:8] <= rx_data;
                        if (hdr_len > LEN_W'(MEM_BYTES)) begin
                            state <= ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else if (hdr_len == '0) begin
                            state <= CHK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= count_q[ADDR_W-1:0];
                        mem_wdata <= rx_data;
                        count_q   <= count_q + CNT_W'(1);
                        chk_q     <= chk8_add(chk_q, rx_data);
                        if (LEN_W'(count_q) == len_q - LEN_W'(1)) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (rx_data == chk_q) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus, popped by a write monitor.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] bytes_written;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  pay[256];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .MEM_BYTES(256)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .bytes_written(bytes_written)
    );

    // Write monitor: every mem_we must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%02h data=%02h (none expected)", mem_addr, mem_wdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%02h data=%02h want addr=%02h data=%02h",
                             mem_addr, mem_wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rx_ready && t < 50) begin t++; @(negedge clk); end
        if (!rx_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout got rx_ready=0 want 1");
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'hEE;
    endtask

    task automatic status(input string name, input logic d, input logic e,
                          input logic h, input logic [8:0] bw);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({name, "_done"}, 32'(done), 32'(d));
        check({name, "_error"}, 32'(error), 32'(e));
        check({name, "_hold"}, 32'(cpu_hold), 32'(h));
        check({name, "_busy"}, 32'(busy), 32'(0));
        check({name, "_bw"}, 32'(bytes_written), 32'(bw));
        check({name, "_pending"}, 32'(exp_q.size()), 32'(0));
    endtask

    // Frame of n bytes from pay[], checksum offset by chk_delta (0 = correct).
    task automatic run_frame(input int n, input int gap_max, input logic [7:0] chk_delta);
        logic [7:0]  sum;
        logic [15:0] nn;
        nn  = 16'(n);
        sum = 8'h00;
        start_pulse();
        send(nn[7:0], 0);
        send(nn[15:8], 0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'(i), pay[i]});
            sum = sum + pay[i];
            send(pay[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        send(sum + chk_delta, 0);
    endtask

    task automatic check_reset_values(input string name);
        @(negedge clk);
        check({name, "_ready"}, 32'(rx_ready), 32'(0));
        check({name, "_we"}, 32'(mem_we), 32'(0));
        check({name, "_addr"}, 32'(mem_addr), 32'(0));
        check({name, "_wdata"}, 32'(mem_wdata), 32'(0));
        check({name, "_hold"}, 32'(cpu_hold), 32'(1));
        check({name, "_busy"}, 32'(busy), 32'(0));
        check({name, "_done"}, 32'(done), 32'(0));
        check({name, "_error"}, 32'(error), 32'(0));
        check({name, "_bw"}, 32'(bytes_written), 32'(0));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        check_reset_values("reset");
        #1 reset = 1'b0;

        // Valid while idle must not be consumed or written.
        rx_valid = 1'b1; rx_data = 8'hAB;
        repeat (4) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(rx_ready), 32'(0));
        check("idle_hold", 32'(cpu_hold), 32'(1));

        // Basic load 04 00 13 00 10 00 23.
        pay[0] = 8'h13; pay[1] = 8'h00; pay[2] = 8'h10; pay[3] = 8'h00;
        run_frame(4, 0, 8'h00);
        status("basic", 1'b1, 1'b0, 1'b0, 9'd4);

        // Same frame with checksum 0x24.
        run_frame(4, 0, 8'h01);
        status("badchk", 1'b0, 1'b1, 1'b1, 9'd4);

        // Oversize header N=257.
        start_pulse();
        send(8'h01, 0);
        send(8'h01, 0);
        status("oversize", 1'b0, 1'b1, 1'b1, 9'd0);

        // Zero length: 00 00 00 passes, 00 00 05 fails.
        run_frame(0, 0, 8'h00);
        status("zero_ok", 1'b1, 1'b0, 1'b0, 9'd0);
        run_frame(0, 0, 8'h05);
        status("zero_bad", 1'b0, 1'b1, 1'b1, 9'd0);

        // Backpressure: random gaps between bytes.
        for (int i = 0; i < 8; i++) pay[i] = 8'(8'hA0 + 8'(i * 7));
        run_frame(8, 3, 8'h00);
        status("gaps", 1'b1, 1'b0, 1'b0, 9'd8);

        // Full 256-byte frame at one byte per cycle.
        for (int i = 0; i < 256; i++) pay[i] = 8'(i) ^ 8'h5A;
        run_frame(256, 0, 8'h00);
        status("full", 1'b1, 1'b0, 1'b0, 9'd256);

        // Reset after two payload bytes: second write is still pending and must be cancelled.
        pay[0] = 8'h11; pay[1] = 8'h22;
        start_pulse();
        send(8'h04, 0);
        send(8'h00, 0);
        exp_q.push_back({8'h00, 8'h11});
        send(8'h11, 0);
        send(8'h22, 0);
        reset = 1'b1;
        check_reset_values("midreset");
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midreset_pending", 32'(exp_q.size()), 32'(0));
        check("midreset_hold", 32'(cpu_hold), 32'(1));

        // Start while busy is ignored.
        pay[0] = 8'h13; pay[1] = 8'h00; pay[2] = 8'h10; pay[3] = 8'h00;
        start_pulse();
        send(8'h04, 0);
        send(8'h00, 0);
        exp_q.push_back({8'h00, 8'h13});
        send(8'h13, 0);
        start_pulse();
        exp_q.push_back({8'h01, 8'h00});
        send(8'h00, 0);
        exp_q.push_back({8'h02, 8'h10});
        send(8'h10, 0);
        exp_q.push_back({8'h03, 8'h00});
        send(8'h00, 0);
        send(8'h23, 0);
        status("busy_start", 1'b1, 1'b0, 1'b0, 9'd4);

        // Reload from ERR.
        run_frame(4, 0, 8'h07);
        status("to_err", 1'b0, 1'b1, 1'b1, 9'd4);
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE;
        run_frame(3, 1, 8'h00);
        status("from_err", 1'b1, 1'b0, 1'b0, 9'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
